counter_csr_ctrl: RTL

//  Sequencer between the CSR execute stage and the machine counter block. Accepts one
//  CSR read/write request at a time (valid/ready), decodes counter CSR addresses and

---
 rtl/counter_csr_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/counter_csr_ctrl.sv
// Sequencer between the CSR execute stage and the machine counter block: counter CSR decode,
// mcountinhibit ownership and response handshake. Optional high-half snapshot: COUNTER_SNAPSHOT_EN.
module counter_csr_ctrl #(
  parameter logic [2:0]  MCOUNTINHIBIT_RESET = 3'b000,
  parameter logic [11:0] MCOUNTINHIBIT       = 12'h320
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_wr_in,
  input  logic [11:0] req_addr_in,
  input  logic [31:0] req_data_in,
  output logic        resp_valid_out,
  input  logic        resp_ready_in,
  output logic [31:0] resp_data_out,
  output logic        resp_err_out,
  input  logic        retire_in,
  input  logic [63:0] mcycle_in,
  input  logic [63:0] minstret_in,
  input  logic [63:0] mtime_in,
  output logic        cnt_wr_en_out,
  output logic [11:0] cnt_addr_out,
  output logic [31:0] cnt_data_out,
  output logic        mcountinhibit_cy_out,
  output logic        mcountinhibit_ir_out,
  output logic        instret_inc_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,
    SRC_CYCLE   = 2'd1,
    SRC_INSTRET = 2'd2,
    SRC_TIME    = 2'd3
  } src_e;

  state_e      state_q, state_d;
  logic        req_wr_q, req_wr_d;
  logic [11:0] req_addr_q, req_addr_d;
  logic [31:0] req_data_q, req_data_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic [11:0] cnt_addr_q, cnt_addr_d;
  logic [31:0] cnt_data_q, cnt_data_d;
  logic        inh_cy_q, inh_cy_d;
  logic        inh_ir_q, inh_ir_d;

  // Address decode of the latched request
  src_e        src_sel;
  logic        src_hi;
  logic [63:0] src_word;
  logic        inh_hit;
  logic        cnt_wr_hit;
  logic        rd_hit;
  logic [31:0] rd_live;
  logic [31:0] rd_data;

`ifdef COUNTER_SNAPSHOT_EN
  logic        snap_valid_q, snap_valid_d;
  src_e        snap_src_q, snap_src_d;
  logic [31:0] snap_data_q, snap_data_d;
  logic        snap_hit;
`endif

  always_comb begin
    src_sel = SRC_NONE;
    src_hi  = 1'b0;
    unique case (req_addr_q)
      12'hB00, 12'hC00: src_sel = SRC_CYCLE;
      12'hB80, 12'hC80: begin src_sel = SRC_CYCLE;   src_hi = 1'b1; end
      12'hB02, 12'hC02: src_sel = SRC_INSTRET;
      12'hB82, 12'hC82: begin src_sel = SRC_INSTRET; src_hi = 1'b1; end
      12'hC01:          src_sel = SRC_TIME;
      12'hC81:          begin src_sel = SRC_TIME;    src_hi = 1'b1; end
      default: ;
    endcase

    unique case (src_sel)
      SRC_CYCLE:   src_word = mcycle_in;
      SRC_INSTRET: src_word = minstret_in;
      SRC_TIME:    src_word = mtime_in;
      default:     src_word = 64'd0;
    endcase

    inh_hit    = (req_addr_q == MCOUNTINHIBIT);
    rd_live    = src_hi ? src_word[63:32] : src_word[31:0];
    rd_hit     = inh_hit || (src_sel != SRC_NONE);
    // Only the 0xBxx aliases of mcycle/minstret are writable; 0xCxx and mtime are read-only
    cnt_wr_hit = !inh_hit && (src_sel == SRC_CYCLE || src_sel == SRC_INSTRET) &&
                 (req_addr_q[11:8] == 4'hB);

`ifdef COUNTER_SNAPSHOT_EN
    snap_hit = snap_valid_q && src_hi && (snap_src_q == src_sel) && !inh_hit;
    rd_data  = snap_hit ? snap_data_q : rd_live;
`else
    rd_data  = rd_live;
`endif
    if (inh_hit) begin
      rd_data = {29'd0, inh_ir_q, 1'b0, inh_cy_q};
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    req_wr_d      = req_wr_q;
    req_addr_d    = req_addr_q;
    req_data_d    = req_data_q;
    resp_data_d   = resp_data_q;
    resp_err_d    = resp_err_q;
    cnt_addr_d    = cnt_addr_q;
    cnt_data_d    = cnt_data_q;
    inh_cy_d      = inh_cy_q;
    inh_ir_d      = inh_ir_q;
    req_ready_out  = 1'b0;
    resp_valid_out = 1'b0;
    cnt_wr_en_out  = 1'b0;
`ifdef COUNTER_SNAPSHOT_EN
    snap_valid_d  = snap_valid_q;
    snap_src_d    = snap_src_q;
    snap_data_d   = snap_data_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) begin
          req_wr_d   = req_wr_in;
          req_addr_d = req_addr_in;
          req_data_d = req_data_in;
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_d     = ST_SETTLE;
        resp_data_d = 32'd0;
        resp_err_d  = 1'b0;
        if (req_wr_q) begin
          if (cnt_wr_hit) begin
            cnt_wr_en_out = 1'b1;
            cnt_addr_d    = req_addr_q;
            cnt_data_d    = req_data_q;
          end else if (inh_hit) begin
            inh_cy_d = req_data_q[0];
            inh_ir_d = req_data_q[2];
          end else begin
            resp_err_d = 1'b1;
          end
        end else if (rd_hit) begin
          resp_data_d = rd_data;
        end else begin
          resp_err_d = 1'b1;
        end
`ifdef COUNTER_SNAPSHOT_EN
        // A low-half read arms the snapshot; every other request disarms it
        snap_valid_d = !req_wr_q && !inh_hit && (src_sel != SRC_NONE) && !src_hi;
        if (snap_valid_d) begin
          snap_src_d  = src_sel;
          snap_data_d = src_word[63:32];
        end
`endif
      end

      ST_SETTLE: begin
        state_d = ST_RESP;
      end

      ST_RESP: begin
        resp_valid_out = 1'b1;
        if (resp_ready_in) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cnt_addr_out = cnt_wr_en_out ? req_addr_q : cnt_addr_q;
    cnt_data_out = cnt_wr_en_out ? req_data_q : cnt_data_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      req_wr_q    <= 1'b0;
      req_addr_q  <= 12'd0;
      req_data_q  <= 32'd0;
      resp_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
      cnt_addr_q  <= 12'd0;
      cnt_data_q  <= 32'd0;
      inh_cy_q    <= MCOUNTINHIBIT_RESET[0];
      inh_ir_q    <= MCOUNTINHIBIT_RESET[2];
    end else begin
      state_q     <= state_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      cnt_addr_q  <= cnt_addr_d;
      cnt_data_q  <= cnt_data_d;
      inh_cy_q    <= inh_cy_d;
      inh_ir_q    <= inh_ir_d;
    end
  end

`ifdef COUNTER_SNAPSHOT_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      snap_valid_q <= 1'b0;
      snap_src_q   <= SRC_NONE;
      snap_data_q  <= 32'd0;
    end else begin
      snap_valid_q <= snap_valid_d;
      snap_src_q   <= snap_src_d;
      snap_data_q  <= snap_data_d;
    end
  end
`endif

  assign resp_data_out        = resp_data_q;
  assign resp_err_out         = resp_err_q;
  assign mcountinhibit_cy_out = inh_cy_q;
  assign mcountinhibit_ir_out = inh_ir_q;
  assign instret_inc_out      = retire_in;

endmodule
